// File: rtl/fir_avg_out_stage.sv
// rtl/fir_avg_out_stage.sv - FIR sum warm-up discard, divide-by-4 average and output FIFO
// Optional build macro FIR_AVG_ROUND_EN selects round-half-up instead of truncation.
module fir_avg_out_stage #(
    parameter int W      = 4,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [W+1:0]               s_in,
    input  logic                       s_valid,
    output logic [W-1:0]               avg_out,
    output logic                       avg_valid,
    input  logic                       avg_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow,
    output logic                       running
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    localparam logic [CW:0]   WARMUP_N = (CW + 1)'(WARMUP);
    localparam logic [FW-1:0] FULL_N   = FW'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] warm_cnt_q, warm_cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          overflow_q, overflow_d;

    logic [W-1:0]  avg;
    logic [CW:0]   warm_cnt_inc;
    logic          push, pop, full, wr_en;

`ifdef FIR_AVG_ROUND_EN
    assign avg = W'(({1'b0, s_in} + (W + 3)'(2)) >> 2);
`else
    assign avg = W'(s_in >> 2);
`endif

    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        overflow_d   = overflow_q;
        warm_cnt_inc = {1'b0, warm_cnt_q} + (CW + 1)'(1);

        full  = (fill_q == FULL_N);
        pop   = (fill_q != '0) && avg_ready;
        push  = (state_q == ST_RUN) && s_valid;
        // A pop on the same edge frees the slot, so a push at full still succeeds.
        wr_en = push && (!full || pop);

        if (state_q == ST_WARMUP) begin
            if (WARMUP == 0) begin
                state_d = ST_RUN;
            end else if (s_valid) begin
                warm_cnt_d = warm_cnt_inc[CW-1:0];
                if (warm_cnt_inc == WARMUP_N) begin
                    state_d = ST_RUN;
                end
            end
        end

        if (wr_en) begin
            mem_d[wr_ptr_q] = avg;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end

        if (reset) begin
            state_d    = ST_WARMUP;
            warm_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        warm_cnt_q <= warm_cnt_d;
        mem_q      <= mem_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        fill_q     <= fill_d;
        overflow_q <= overflow_d;
    end

    // Storage is not cleared on reset, so the head is masked while empty.
    assign avg_valid = (fill_q != '0);
    assign avg_out   = avg_valid ? mem_q[rd_ptr_q] : '0;
    assign fill      = fill_q;
    assign overflow  = overflow_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_fir_avg_out_stage.sv
// tb/tb_fir_avg_out_stage.sv - scoreboard bench for fir_avg_out_stage
module tb_fir_avg_out_stage;

    localparam int W      = 4;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 3;
    localparam int FW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [W+1:0]  s_in;
    logic          s_valid;
    logic [W-1:0]  avg_out;
    logic          avg_valid;
    logic          avg_ready;
    logic [FW-1:0] fill;
    logic          overflow;
    logic          running;

    fir_avg_out_stage #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .fill      (fill),
        .overflow  (overflow),
        .running   (running)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: occupancy count, sticky flag, sums seen in warm-up, expected queue.
    logic [W-1:0] exp_q [$];
    int m_fill = 0;
    bit m_ovf  = 0;
    bit m_run  = 0;
    int m_seen = 0;

    function automatic int ref_avg(input int s);
`ifdef FIR_AVG_ROUND_EN
        return ((s + 2) / 4) % (1 << W);
`else
        return (s / 4) % (1 << W);
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: check registered state, drive inputs for the next edge, advance the model.
    task automatic step(input bit r, input bit sv, input int s, input bit rdy);
        bit do_pop;
        int f0;
        chk("fill", int'(fill), m_fill);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("running", int'(running), int'(m_run));
        chk("avg_valid", int'(avg_valid), int'(m_fill > 0));

        reset     = r;
        s_valid   = sv;
        s_in      = (W + 2)'(s);
        avg_ready = rdy;

        if (r) begin
            exp_q.delete();
            m_fill = 0;
            m_ovf  = 0;
            m_run  = 0;
            m_seen = 0;
        end else begin
            f0     = m_fill;
            do_pop = (f0 > 0) && rdy;
            if (do_pop) m_fill--;
            if (m_run && sv) begin
                if (f0 < DEPTH || do_pop) begin
                    exp_q.push_back(W'(ref_avg(s)));
                    m_fill++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (!m_run) begin
                if (sv) m_seen++;
                if (m_seen >= WARMUP) m_run = 1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a value.
    bit           hold_chk = 0;
    logic [W-1:0] held_val;
    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 0;
        end else begin
            if (hold_chk) chk("hold_stable", int'(avg_out), int'(held_val));
            if (avg_valid && avg_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", int'(avg_out), -1);
                end else begin
                    chk("avg_out", int'(avg_out), int'(exp_q.pop_front()));
                end
            end
            hold_chk = avg_valid && !avg_ready;
            held_val = avg_out;
        end
    end

    initial begin
        int v [4];
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_in      = '0;
        avg_ready = 1'b0;
        @(posedge clk);
        #2;
        step(1, 0, 0, 0);

        // Warm-up: 8,16,24 dropped, 32 kept as 8
        v = '{8, 16, 24, 32};
        foreach (v[i]) step(0, 1, v[i], 1);
        repeat (3) step(0, 0, 0, 1);

        // Rounding cases
        v = '{6, 5, 58, 0};
        foreach (v[i]) step(0, 1, v[i], 1);
        repeat (3) step(0, 0, 0, 1);

        // Fill to full and overflow, hold back-pressure, then drain
        for (int i = 1; i <= 5; i++) step(0, 1, 4 * i, 0);
        repeat (5) step(0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 1);

        // Simultaneous push and pop at full
        step(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, i, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 20 + 4 * i, 0);
        step(0, 1, 40, 1);
        repeat (6) step(0, 0, 0, 1);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) step(0, 1, 44 + 4 * i, 0);
        step(1, 0, 0, 0);
        v = '{12, 12, 12, 60};
        foreach (v[i]) step(0, 1, v[i], 1);
        repeat (3) step(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 60,
                 int'($urandom_range(4 * ((1 << W) - 1))), $urandom_range(99) < 50);
        end

        repeat (2 * DEPTH) step(0, 0, 0, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
